rob_rename_unit: RTL

- Reorder buffer with integrated register-rename table for the Tomasulo core.
- Sits upstream of the reservation stations. At issue it allocates a ROB slot and returns rob_ind, plus per-source ready bits (rs1_b/rs2_b) and producer tags.
- Downstream, it accepts execution-unit writebacks and retires results to the register bank strictly in program order, one per cycle.

---
 rtl/rob_rename_unit_if.sv | 66 ++++++
 rtl/rob_rename_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rob_rename_unit_if.sv
// rob_rename_unit_if
//   Issue / writeback / retire bundle between the Tomasulo front end and the
//   reorder buffer with its integrated rename table.
//
//   Issue group : alloc_valid, alloc_func, alloc_rd -> alloc_ready, alloc_idx
//   Lookup group: src1_reg, src2_reg -> src*_b, src*_tag, src*_data
//   Writeback   : wb_valid, wb_rob_ind, wb_data
//   Retire      : commit_valid, commit_wen, commit_rd, commit_data, commit_rob_ind
//   Status      : count, wb_err
//
//   modport master : issue stage / execution units / register bank side
//   modport slave  : the reorder buffer itself
interface rob_rename_unit_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
);
  localparam int IDX_W = $clog2(DEPTH);

  logic              alloc_valid;
  logic [3:0]        alloc_func;
  logic [3:0]        alloc_rd;
  logic              alloc_ready;
  logic [IDX_W-1:0]  alloc_idx;

  logic [3:0]        src1_reg;
  logic [3:0]        src2_reg;
  logic              src1_b;
  logic              src2_b;
  logic [IDX_W-1:0]  src1_tag;
  logic [IDX_W-1:0]  src2_tag;
  logic [DATA_W-1:0] src1_data;
  logic [DATA_W-1:0] src2_data;

  logic              wb_valid;
  logic [IDX_W-1:0]  wb_rob_ind;
  logic [DATA_W-1:0] wb_data;

  logic              commit_valid;
  logic              commit_wen;
  logic [3:0]        commit_rd;
  logic [DATA_W-1:0] commit_data;
  logic [IDX_W-1:0]  commit_rob_ind;

  logic [IDX_W:0]    count;
  logic              wb_err;

  modport master (
    output alloc_valid, alloc_func, alloc_rd,
    output src1_reg, src2_reg,
    output wb_valid, wb_rob_ind, wb_data,
    input  alloc_ready, alloc_idx,
    input  src1_b, src2_b, src1_tag, src2_tag, src1_data, src2_data,
    input  commit_valid, commit_wen, commit_rd, commit_data, commit_rob_ind,
    input  count, wb_err
  );

  modport slave (
    input  alloc_valid, alloc_func, alloc_rd,
    input  src1_reg, src2_reg,
    input  wb_valid, wb_rob_ind, wb_data,
    output alloc_ready, alloc_idx,
    output src1_b, src2_b, src1_tag, src2_tag, src1_data, src2_data,
    output commit_valid, commit_wen, commit_rd, commit_data, commit_rob_ind,
    output count, wb_err
  );
endinterface

// File: rtl/rob_rename_unit.sv
// rob_rename_unit
//   Reorder buffer with integrated register-rename table. Allocates a slot
//   per issued instruction, answers source-operand lookups (ready bit and
//   producer tag), buffers out-of-order writebacks and retires results in
//   program order, at most one per cycle.
//
//   Ports:
//     clk1 : clock
//     rst  : synchronous active-high reset
//     bus  : rob_rename_unit_if.slave (issue, lookup, writeback, retire,
//            occupancy count and sticky writeback-error flag)
//
//   Build option:
//     ROB_FWD_EN : when defined, a source whose producer has completed but not
//                  yet retired is reported ready and its value is forwarded on
//                  src*_data. Undefined, readiness follows the rename table
//                  only and src*_data is zero.
module rob_rename_unit #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int NREG   = 16
) (
  input logic           clk1,
  input logic           rst,
  rob_rename_unit_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] FULL_COUNT = (IDX_W + 1)'(DEPTH);

  // Stores and branches never write a destination register.
  function automatic logic writes_rd(input logic [3:0] f);
    logic w;
    case (f)
      4'b0101, 4'b0110, 4'b0111: w = 1'b0;
      default:                   w = 1'b1;
    endcase
    return w;
  endfunction

  logic              busy  [DEPTH];
  logic              done  [DEPTH];
  logic [3:0]        func  [DEPTH];
  logic [3:0]        rd    [DEPTH];
  logic [DATA_W-1:0] value [DEPTH];

  logic              rat_valid [NREG];
  logic [IDX_W-1:0]  rat_tag   [NREG];

  logic [IDX_W-1:0]  head;
  logic [IDX_W-1:0]  tail;
  logic [IDX_W:0]    count;

  logic              commit_valid;
  logic              commit_wen;
  logic [3:0]        commit_rd;
  logic [DATA_W-1:0] commit_data;
  logic [IDX_W-1:0]  commit_rob_ind;
  logic              wb_err;

  logic alloc_ready;
  logic alloc_fire;
  logic commit_fire;

  // Fullness comes from the registered count, so a full ROB refuses
  // allocation even on the cycle its head retires.
  assign alloc_ready = (count != FULL_COUNT);
  assign alloc_fire  = bus.alloc_valid && alloc_ready;
  assign commit_fire = busy[head] && done[head];

  assign bus.alloc_ready    = alloc_ready;
  assign bus.alloc_idx      = tail;
  assign bus.count          = count;
  assign bus.commit_valid   = commit_valid;
  assign bus.commit_wen     = commit_wen;
  assign bus.commit_rd      = commit_rd;
  assign bus.commit_data    = commit_data;
  assign bus.commit_rob_ind = commit_rob_ind;
  assign bus.wb_err         = wb_err;

  // Lookups read pre-edge state, so an instruction naming its own rd as a
  // source sees the older producer rather than itself.
  assign bus.src1_tag = rat_tag[bus.src1_reg];
  assign bus.src2_tag = rat_tag[bus.src2_reg];

`ifdef ROB_FWD_EN
  logic src1_fwd;
  logic src2_fwd;

  // A completed but unretired producer can hand its value over directly.
  // done is registered, so a writeback landing this edge forwards next cycle.
  always_comb begin
    src1_fwd      = rat_valid[bus.src1_reg] && done[rat_tag[bus.src1_reg]];
    src2_fwd      = rat_valid[bus.src2_reg] && done[rat_tag[bus.src2_reg]];
    bus.src1_b    = !rat_valid[bus.src1_reg] || src1_fwd;
    bus.src2_b    = !rat_valid[bus.src2_reg] || src2_fwd;
    bus.src1_data = src1_fwd ? value[rat_tag[bus.src1_reg]] : '0;
    bus.src2_data = src2_fwd ? value[rat_tag[bus.src2_reg]] : '0;
  end
`else
  assign bus.src1_b    = !rat_valid[bus.src1_reg];
  assign bus.src2_b    = !rat_valid[bus.src2_reg];
  assign bus.src1_data = '0;
  assign bus.src2_data = '0;
`endif

  // Writeback, retire and allocate share one register block. The three
  // never fight over a slot: a writeback to the retiring head is already
  // done (error path), and a writeback to the tail hits a non-busy slot.
  // Within the rename table the allocation update is written last so a
  // same-edge rename of the retiring rd keeps rat_valid with the new tag.
  always_ff @(posedge clk1) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      commit_valid   <= 1'b0;
      commit_wen     <= 1'b0;
      commit_rd      <= '0;
      commit_data    <= '0;
      commit_rob_ind <= '0;
      wb_err         <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        busy[i] <= 1'b0;
        done[i] <= 1'b0;
      end
      for (int r = 0; r < NREG; r++) begin
        rat_valid[r] <= 1'b0;
      end
    end else begin
      if (bus.wb_valid) begin
        if (busy[bus.wb_rob_ind] && !done[bus.wb_rob_ind]) begin
          done[bus.wb_rob_ind]  <= 1'b1;
          value[bus.wb_rob_ind] <= bus.wb_data;
        end else begin
          wb_err <= 1'b1;
        end
      end

      if (commit_fire) begin
        commit_valid   <= 1'b1;
        commit_wen     <= writes_rd(func[head]);
        commit_rd      <= rd[head];
        commit_data    <= value[head];
        commit_rob_ind <= head;
        busy[head]     <= 1'b0;
        done[head]     <= 1'b0;
        // Only drop the mapping if no younger instruction has renamed rd.
        if (writes_rd(func[head]) && rat_valid[rd[head]] &&
            (rat_tag[rd[head]] == head)) begin
          rat_valid[rd[head]] <= 1'b0;
        end
        head <= head + 1'b1;
      end else begin
        commit_valid <= 1'b0;
      end

      if (alloc_fire) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
        func[tail] <= bus.alloc_func;
        rd[tail]   <= bus.alloc_rd;
        if (writes_rd(bus.alloc_func)) begin
          rat_valid[bus.alloc_rd] <= 1'b1;
          rat_tag[bus.alloc_rd]   <= tail;
        end
        tail <= tail + 1'b1;
      end

      case ({alloc_fire, commit_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
